mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator side of the single-port word memory interface.
- Accepts burst read/write requests from the core over a valid/ready handshake.
- Drives the memory's addr / data_in / en_write, samples its combinational data_out, and streams words in and out.
- Sits between the CPU control path and the memory block; the memory reads combinationally and writes on the clock edge.

Parameters:
WORD_SIZE, 16, data word width; matches the memory.
ADDR_SIZE, 16, address width; matches the memory.
LEN_SIZE, 8, burst length field width; a burst is req_len+1 words, 1..2^LEN_SIZE.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_SIZE  burst start address
req_len  in  LEN_SIZE  beats minus one
wr_valid  in  1  write word present
wr_ready  out  1  write word consumed when valid&ready
wr_data  in  WORD_SIZE  write word
rd_valid  out  1  read word present
rd_ready  in  1  read word consumed when valid&ready
rd_data  out  WORD_SIZE  read word (registered)
done  out  1  one-cycle pulse after the last beat of a burst
err  out  1  sticky verify mismatch (optional feature only)
mem_addr  out  ADDR_SIZE  to memory addr
mem_data_in  out  WORD_SIZE  to memory data_in
mem_en_write  out  1  to memory en_write
mem_data_out  in  WORD_SIZE  from memory data_out

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; cur_addr=0; beat count=0; rd_data=0; rd_valid=0; done=0; err=0. req_ready, wr_ready, mem_en_write and mem_addr are decoded from state, so they read 1, 0, 0, 0 during reset. Reset mid-burst abandons the burst immediately: no further writes, no done pulse.
- IDLE: req_ready=1. On req_valid, latch req_addr into cur_addr and req_len into len, clear count, then go to WRITE or READ_ISSUE per req_write. Request fields are ignored outside IDLE.
- WRITE: mem_addr=cur_addr; mem_data_in=wr_data; wr_ready=1; mem_en_write=wr_valid (combinational). Each accepted beat is written on that edge.
  - If count==len: go to IDLE, done=1 next cycle.
  - Else: cur_addr+1, count+1.
  - wr_valid low means stall with no write. Throughput: 1 word/cycle.
- READ_ISSUE: mem_addr=cur_addr. On the edge, capture mem_data_out into rd_data, set rd_valid=1, go to READ_HOLD.
- READ_HOLD: rd_valid=1; rd_data is held stable while rd_ready is low.
  - On rd_ready: rd_valid=0 next cycle.
  - If count==len: go to IDLE, done=1.
  - Else: cur_addr+1, count+1, go to READ_ISSUE.
  - Throughput: 1 word/2 cycles. Read latency from request accept to first rd_valid: 2 cycles.
- Address arithmetic is modulo 2^ADDR_SIZE: 0xFFFF+1 wraps to 0x0000 silently.
- Length: req_len=0 gives 1 beat; all-ones gives 2^LEN_SIZE beats.
- done asserts for exactly 1 cycle, in the cycle IDLE is re-entered. A new request may be accepted in that same cycle.
- mem_en_write is never asserted outside WRITE.

Optional Feature:
MEM_MASTER_VERIFY_EN
- Defined:
  - Each accepted write beat latches wr_data and moves to VERIFY; wr_ready=0 in VERIFY.
  - VERIFY drives mem_addr=cur_addr and compares mem_data_out to the latched word; a mismatch sets err, which is sticky.
  - VERIFY then advances address/count exactly as WRITE would (or goes to IDLE with done). Write throughput drops to 1 word/2 cycles.
  - err clears on the next request accept or on reset.
- Undefined: no VERIFY state exists; err is tied to 0; write timing is exactly as described above.

Test Plan:
- Write burst addr=0x0010 len=3 data 0xA000..0xA003, wr_valid held high -> mem_en_write high 4 consecutive cycles at 0x0010..0x0013; done pulses once; memory holds the values.
- Read burst addr=0x0010 len=3 after the above, rd_ready=1 -> rd_data 0xA000,0xA001,0xA002,0xA003 in order; first rd_valid 2 cycles after accept; 1 word per 2 cycles; done once.
- Write addr=0xFFFF len=1 data 0x1111,0x2222 -> words land at 0xFFFF then 0x0000; reading them back returns the same values.
- Read with rd_ready low 5 cycles on beat 1 -> rd_valid and rd_data stable throughout; no address advance; no beat lost or duplicated.
- Write len=7 with rst pulsed low after beat 3 -> mem_en_write drops at once; only 3 words written; req_ready=1 after release; no done pulse.
- With MEM_MASTER_VERIFY_EN and a memory model forcing bit0=0 at 0x0020, write 0x0001 -> err=1 and stays set through done; next accepted request clears err.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: burst read/write initiator for the single-port word memory; MEM_MASTER_VERIFY_EN adds write read-back verify.
module mem_master #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int LEN_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LEN_SIZE-1:0]  req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data_in,
  output logic                 mem_en_write,
  input  logic [WORD_SIZE-1:0] mem_data_out
);
`ifdef MEM_MASTER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ_ISSUE, READ_HOLD, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_HOLD} state_t;
`endif
  state_t state, state_n;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [LEN_SIZE-1:0] len, count;
  logic last, accept, advance;
  assign last = count == len;
  assign accept = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  assign wr_ready = state == WRITE;
  assign mem_en_write = state == WRITE && wr_valid;
  assign mem_addr = state == IDLE ? '0 : cur_addr;
  assign mem_data_in = wr_data;
  assign rd_valid = state == READ_HOLD;
  // advance marks the completion of a beat: address/count step or burst end
  always_comb begin
    state_n = state;
    advance = 1'b0;
    case (state)
      IDLE: state_n = req_valid ? (req_write ? WRITE : READ_ISSUE) : IDLE;
`ifdef MEM_MASTER_VERIFY_EN
      WRITE: state_n = wr_valid ? VERIFY : WRITE;
      VERIFY: begin
        advance = 1'b1;
        state_n = last ? IDLE : WRITE;
      end
`else
      WRITE: begin
        advance = wr_valid;
        state_n = wr_valid && last ? IDLE : WRITE;
      end
`endif
      READ_ISSUE: state_n = READ_HOLD;
      READ_HOLD: begin
        advance = rd_ready;
        state_n = rd_ready ? (last ? IDLE : READ_ISSUE) : READ_HOLD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr <= '0;
      len <= '0;
      count <= '0;
      rd_data <= '0;
      done <= 1'b0;
    end else begin
      done <= advance && last;
      if (accept) begin
        cur_addr <= req_addr;
        len <= req_len;
        count <= '0;
      end else if (advance && !last) begin
        cur_addr <= cur_addr + ADDR_SIZE'(1);
        count <= count + LEN_SIZE'(1);
      end
      if (state == READ_ISSUE) rd_data <= mem_data_out;
    end
  end
`ifdef MEM_MASTER_VERIFY_EN
  logic [WORD_SIZE-1:0] wr_latch;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_latch <= '0;
      err <= 1'b0;
    end else begin
      if (mem_en_write) wr_latch <= wr_data;
      if (accept) err <= 1'b0;
      else if (state == VERIFY && mem_data_out != wr_latch) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized scoreboard bench for mem_master against a word-array memory model.
module tb_mem_master;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_write = 0, wr_valid = 0, rd_ready = 0;
  logic [15:0] req_addr = 0, wr_data = 0;
  logic [7:0] req_len = 0;
  logic req_ready, wr_ready, rd_valid, done, err, mem_en_write;
  logic [15:0] rd_data, mem_addr, mem_data_in, mem_data_out;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [31:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] wdata[$];
  int tests = 0, fails = 0, exp_done = 0, got_done = 0;
  logic prev_done = 0;
  time t_acc;

  always #5 clk = ~clk;

  mem_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_en_write(mem_en_write), .mem_data_out(mem_data_out)
  );

  function automatic logic [15:0] stored(input logic [15:0] a, input logic [15:0] d);
`ifdef MEM_MASTER_VERIFY_EN
    return a == 16'h0020 ? (d & 16'hFFFE) : d;
`else
    return a == 16'hFFFF ? d : d;
`endif
  endfunction

  assign mem_data_out = mem[mem_addr];
  always @(posedge clk) if (mem_en_write) mem[mem_addr] <= stored(mem_addr, mem_data_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops expected write beats / read words as the DUT presents them
  always @(negedge clk) if (rst) begin
    if (mem_en_write) begin
      check("en_write_in_write", {31'd0, wr_ready}, 32'd1);
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL write_unexpected: got addr %h data %h, no write expected", mem_addr, mem_data_in);
      end else check("write_beat", {mem_addr, mem_data_in}, wr_q.pop_front());
    end
    if (rd_valid && rd_ready) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL read_unexpected: got %h, no read expected", rd_data);
      end else check("read_word", {16'd0, rd_data}, {16'd0, rd_q.pop_front()});
    end
    if (done) begin
      got_done++;
      check("done_width", {31'd0, prev_done}, 32'd0);
    end
    prev_done = done;
  end

  task automatic issue_req(input logic w, input logic [15:0] a, input int len);
    req_valid = 1; req_write = w; req_addr = a; req_len = 8'(len);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    #1;
    req_valid = 0; req_addr = $urandom; req_len = $urandom; req_write = $urandom;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (req_ready) break;
      c++;
    end
    if (c >= 100) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input int len, input int stall, input int stop);
    int n = stop >= 0 ? stop : len + 1;
    int i = 0, cyc = 0;
    logic hs;
    for (int k = 0; k < n; k++) begin
      logic [15:0] a = 16'(addr + k);
      wr_q.push_back({a, wdata[k]});
      ref_mem[a] = stored(a, wdata[k]);
    end
    if (stop < 0) exp_done++;
    issue_req(1, addr, len);
    while (i < n && cyc < 2000) begin
      wr_valid = $urandom_range(99) >= stall;
      wr_data = wdata[i];
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    wr_valid = 0;
    if (cyc >= 2000) check("write_timeout", 32'(i), 32'(n));
`ifdef MEM_MASTER_VERIFY_EN
    if (stall == 0) check("write_cycles", 32'(cyc), 32'(2 * n - 1));
`else
    if (stall == 0) check("write_cycles", 32'(cyc), 32'(n));
`endif
    if (stop < 0) wait_idle();
  endtask

  task automatic do_read(input logic [15:0] addr, input int len, input int stall, input int stall_beat);
    int beat = 0, cyc = 0, hold = 0;
    logic hs;
    logic [15:0] sd, sa;
    time hs_t[$];
    bit ok = 1;
    for (int k = 0; k <= len; k++) rd_q.push_back(ref_mem[16'(addr + k)]);
    exp_done++;
    rd_ready = 0;
    issue_req(0, addr, len);
    while (beat <= len && cyc < 5000) begin
      rd_ready = (beat == stall_beat && hold < 5) ? 1'b0 : ($urandom_range(99) >= stall);
      @(negedge clk);
      if (beat == stall_beat && hold > 0 && hold < 5) begin
        check("stall_valid", {31'd0, rd_valid}, 32'd1);
        check("stall_data", {16'd0, rd_data}, {16'd0, sd});
        check("stall_addr", {16'd0, mem_addr}, {16'd0, sa});
        hold++;
      end else if (beat == stall_beat && hold == 0 && rd_valid) begin
        sd = rd_data; sa = mem_addr; hold = 1;
      end
      hs = rd_valid && rd_ready;
      if (hs) hs_t.push_back($time);
      @(posedge clk); #1;
      cyc++;
      if (hs) beat++;
    end
    rd_ready = 0;
    if (cyc >= 5000) check("read_timeout", 32'(beat), 32'(len + 1));
    if (stall == 0 && stall_beat < 0 && hs_t.size() > 0) begin
      check("rd_latency", 32'(hs_t[0] - t_acc), 32'd15);
      for (int k = 1; k < hs_t.size(); k++) if (hs_t[k] - hs_t[k-1] != 20) ok = 0;
      check("rd_throughput", {31'd0, ok}, 32'd1);
    end
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, bad;
    for (int k = 0; k < 65536; k++) begin mem[k] = 0; ref_mem[k] = 0; end
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_en_write", {31'd0, mem_en_write}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1;
    @(posedge clk); #1;
    wdata = {};
    for (int k = 0; k < 4; k++) wdata.push_back(16'hA000 + 16'(k));
    d0 = got_done;
    do_write(16'h0010, 3, 0, -1);
    check("write_done_once", 32'(got_done - d0), 32'd1);
    d0 = got_done;
    do_read(16'h0010, 3, 0, -1);
    check("read_done_once", 32'(got_done - d0), 32'd1);
    wdata = {16'h1111, 16'h2222};
    do_write(16'hFFFF, 1, 0, -1);
    do_read(16'hFFFF, 1, 0, -1);
    do_read(16'h0010, 3, 0, 1);
    wdata = {};
    for (int k = 0; k < 8; k++) wdata.push_back(16'($urandom));
    d0 = got_done;
    do_write(16'h0100, 7, 0, 3);
    wr_valid = 1; wr_data = wdata[3];
    rst = 0;
    #1;
    check("rst_mid_en_write", {31'd0, mem_en_write}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    wr_valid = 0;
    @(negedge clk); @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("rst_rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_no_done", 32'(got_done - d0), 32'd0);
`ifdef MEM_MASTER_VERIFY_EN
    check("err_before", {31'd0, err}, 32'd0);
    wdata = {16'h0001};
    do_write(16'h0020, 0, 0, -1);
    check("err_set", {31'd0, err}, 32'd1);
    do_read(16'h0020, 0, 0, -1);
    check("err_cleared", {31'd0, err}, 32'd0);
`endif
    for (int t = 0; t < 30; t++) begin
      logic [15:0] a = $urandom_range(3) == 0 ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
      int len = $urandom_range(15);
      if ($urandom_range(1)) begin
        wdata = {};
        for (int k = 0; k <= len; k++) wdata.push_back(16'($urandom));
        do_write(a, len, 30, -1);
      end else do_read(a, len, 30, -1);
    end
    wdata = {};
    for (int k = 0; k < 256; k++) wdata.push_back(16'($urandom));
    do_write(16'hFF80, 255, 20, -1);
    do_read(16'hFF80, 255, 20, -1);
    repeat (3) @(posedge clk);
    #1;
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("done_count", 32'(got_done), 32'(exp_done));
    bad = 0;
    for (int k = 0; k < 65536; k++) if (mem[k] !== ref_mem[k]) bad++;
    check("mem_image", 32'(bad), 32'd0);
`ifndef MEM_MASTER_VERIFY_EN
    check("err_tied", {31'd0, err}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
